fetch_unit: RTL and testbench

//   Instruction-fetch stage and IF/ID pipeline register of the CPU. Owns the program counter and

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 32 +++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch stage and its IF/ID latch.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSN_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] HALT_INSN_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // IF/ID payload: instruction word plus the word address it was fetched from
  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pc;
  } ifid_payload_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: 64-bit payload plus valid, with hold (stall) and squash (flush).
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  ifid_payload_t d,
  output ifid_payload_t q,
  output logic          valid
);

  localparam ifid_payload_t EMPTY = '{instruction: NOP_INSN, pc: '0};

  // Flush wins over hold so a redirect can squash while the hazard unit stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= EMPTY;
      valid <= 1'b0;
    end else if (flush) begin
      q     <= EMPTY;
      valid <= 1'b0;
    end else if (!hold) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handles stall/redirect/HALT, feeds the IF/ID latch.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] PC_INC    = 32'd1,
  parameter logic [XLEN-1:0] HALT_INSN = HALT_INSN_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSN  = NOP_INSN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] ifid_instruction,
  output logic [XLEN-1:0] ifid_pc,
  output logic            ifid_valid,
  output logic            halted
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            halted_nxt;
  logic            ifid_hold;
  logic            ifid_flush;
  ifid_payload_t   ifid_d;
  ifid_payload_t   ifid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      halted <= halted_nxt;
    end
  end

  // Next-state and PC mux; priority redirect > stall > halt-detect > sequential
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    halted_nxt = halted;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    ifid_d     = '{instruction: instruction, pc: pc};

    if (redirect) begin
      pc_nxt     = redirect_pc;
      ifid_flush = 1'b1;
      state_nxt  = RUN;
      halted_nxt = 1'b0;
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else begin
      case (state)
        BOOT: begin
          ifid_flush = 1'b1;
          state_nxt  = RUN;
        end
        RUN: begin
          if (instruction == HALT_INSN) begin
            state_nxt  = HALTED;
            halted_nxt = 1'b1;
          end else begin
            pc_nxt = pc + PC_INC;
          end
        end
        HALTED: begin
          ifid_flush = 1'b1;
        end
        default: begin
          ifid_flush = 1'b1;
          state_nxt  = BOOT;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_INSN (NOP_INSN)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (ifid_hold),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q),
    .valid (ifid_valid)
  );

  assign ifid_instruction = ifid_q.instruction;
  assign ifid_pc          = ifid_q.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural fetch model plus directed literal checks.
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        halted;

  logic [31:0] mem [0:1023];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign instruction = mem[pc[9:0]];

  fetch_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .pc               (pc),
    .instruction      (instruction),
    .ifid_instruction (ifid_instruction),
    .ifid_pc          (ifid_pc),
    .ifid_valid       (ifid_valid),
    .halted           (halted)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: fetch rules applied to the bench's own memory image
  logic [31:0] m_pc, m_ii, m_ipc;
  logic        m_iv, m_halted, m_first;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_ii = NOP; m_ipc = 32'h0; m_iv = 1'b0; m_halted = 1'b0; m_first = 1'b1;
    end else if (redirect) begin
      m_pc = redirect_pc; m_ii = NOP; m_iv = 1'b0; m_halted = 1'b0; m_first = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_first || m_halted) begin
      m_first = 1'b0; m_ii = NOP; m_iv = 1'b0;
    end else begin
      m_ii  = mem[m_pc[9:0]];
      m_ipc = m_pc;
      m_iv  = 1'b1;
      if (m_ii == HALT) m_halted = 1'b1;
      else              m_pc = m_pc + 32'd1;
    end
  end

  // Cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    check("model_pc", pc, m_pc);
    check("model_valid", {31'b0, ifid_valid}, {31'b0, m_iv});
    check("model_halted", {31'b0, halted}, {31'b0, m_halted});
    check("model_ifid_instr", ifid_instruction, m_ii);
    if (m_iv) check("model_ifid_pc", ifid_pc, m_ipc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[5] = HALT;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    repeat (2) tick();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, ifid_valid}, 32'h0);
    check("rst_instr", ifid_instruction, NOP);
    check("rst_ifid_pc", ifid_pc, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);

    // boot edge then sequential fetch
    rst_n = 1'b1;
    tick();
    check("boot_valid", {31'b0, ifid_valid}, 32'h0);
    check("boot_pc", pc, 32'h0);
    tick();
    check("seq_a_instr", ifid_instruction, 32'h1000_0000);
    check("seq_a_pc", ifid_pc, 32'h0);
    check("seq_a_valid", {31'b0, ifid_valid}, 32'h1);
    tick();
    check("seq_b_instr", ifid_instruction, 32'h1000_0001);
    check("seq_b_fetch_pc", pc, 32'h2);

    // three-cycle stall holds PC and IF/ID
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", pc, 32'h2);
      check("stall_ifid_pc", ifid_pc, 32'h1);
      check("stall_valid", {31'b0, ifid_valid}, 32'h1);
    end
    stall = 1'b0;
    tick();
    check("post_stall_instr", ifid_instruction, 32'h1000_0002);
    check("post_stall_ifid_pc", ifid_pc, 32'h2);

    // run into HALT at word 5
    repeat (3) tick();
    check("halt_instr", ifid_instruction, HALT);
    check("halt_ifid_pc", ifid_pc, 32'h5);
    check("halt_valid", {31'b0, ifid_valid}, 32'h1);
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_pc", pc, 32'h5);
    tick();
    check("halted_valid", {31'b0, ifid_valid}, 32'h0);
    check("halted_pc", pc, 32'h5);
    redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    check("unhalt_flag", {31'b0, halted}, 32'h0);
    check("unhalt_pc", pc, 32'h10);
    redirect = 1'b0;
    tick();
    check("resume_instr", ifid_instruction, 32'h1000_0010);
    check("resume_ifid_pc", ifid_pc, 32'h10);

    // redirect beats a simultaneous stall
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    check("redir_pc", pc, 32'h40);
    check("redir_valid", {31'b0, ifid_valid}, 32'h0);
    check("redir_instr", ifid_instruction, NOP);
    stall = 1'b0; redirect = 1'b0;
    tick();
    check("target_instr", ifid_instruction, 32'h1000_0040);
    check("target_ifid_pc", ifid_pc, 32'h40);

    // PC wrap-around
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    check("wrap_pre_pc", pc, 32'hFFFF_FFFF);
    redirect = 1'b0;
    tick();
    check("wrap_pc", pc, 32'h0);
    check("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFF);
    check("wrap_instr", ifid_instruction, 32'h1000_03FF);

    // async reset between edges during a stall with valid IF/ID
    tick();
    stall = 1'b1;
    tick();
    check("pre_areset_valid", {31'b0, ifid_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_pc", pc, 32'h0);
    check("areset_valid", {31'b0, ifid_valid}, 32'h0);
    check("areset_instr", ifid_instruction, NOP);
    check("areset_ifid_pc", ifid_pc, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; stall = 1'b0;
    tick();
    check("reboot_valid", {31'b0, ifid_valid}, 32'h0);
    check("reboot_pc", pc, 32'h0);
    tick();
    check("reboot_instr", ifid_instruction, 32'h1000_0000);
    check("reboot_valid2", {31'b0, ifid_valid}, 32'h1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
